step_pattern_sequencer: RTL and testbench
=========================================

Name: step_pattern_sequencer

Overview:
- Parametrised multi-bit pattern sequencer clocked by the divided step clock `div_clk`. Generalises the two-bit, eight-step LED sequencer.
- Records up to DEPTH patterns of WIDTH bits through a valid/ready write port.
- Plays back only the recorded length, forward, reverse or ping-pong, driving a registered pattern output.
- Sits between debounced or synchronised front-panel logic and the LED/output drivers.

Parameters:
- WIDTH, 2: bits per pattern/output.
- DEPTH, 8: maximum steps stored; must be ≥ 2.
- ADDR_W, $clog2(DEPTH): step index width.

Ports:
- div_clk  in  1  step clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_rec  in  1  one-cycle pulse: enter RECORD, clear length.
- cmd_play  in  1  one-cycle pulse: enter PLAY.
- cmd_stop  in  1  one-cycle pulse: return to IDLE.
- dir  in  2  00 fwd, 01 rev, 10 ping-pong, 11 treated as fwd.
- wr_valid  in  1  write request.
- wr_data  in  WIDTH  pattern to record.
- wr_ready  out  1  write accepted when wr_valid && wr_ready at edge.
- pat_out  out  WIDTH  registered current pattern.
- step_idx  out  ADDR_W  index of pattern shown on pat_out.
- seq_len  out  ADDR_W+1  number of recorded steps, 0..DEPTH.
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY.
- loop_count  in  8  (LOOP_COUNT_EN only) passes to play; 0 = infinite.
- done  out  1  (LOOP_COUNT_EN only) one-cycle pulse at end of finite play.

Behaviour:
- Reset (async): state=IDLE, seq_len=0, pat_out=0, step_idx=0, wr_ready=0, done=0. Memory contents are not reset.
- Command priority when pulses coincide: cmd_stop > cmd_rec > cmd_play.
- IDLE:
  - pat_out=0.
  - cmd_rec → RECORD with seq_len=0.
  - cmd_play → PLAY if seq_len>0, else ignored.
- RECORD:
  - wr_ready = (seq_len < DEPTH), combinational from registered seq_len.
  - On accept: mem[seq_len] ← wr_data, seq_len+1, pat_out ← wr_data (echo), step_idx ← seq_len.
  - Full (seq_len==DEPTH): wr_ready=0; writes ignored; no wrap or overwrite.
  - cmd_play → PLAY if seq_len>0, else IDLE. cmd_stop → IDLE. cmd_rec → restart with seq_len=0.
- PLAY entry (edge N):
  - Pointer ← 0 for fwd/ping-pong, seq_len-1 for rev.
  - Ping-pong direction flag ← up.
  - pat_out unchanged at edge N.
- PLAY, each subsequent edge:
  - pat_out ← mem[ptr], step_idx ← ptr, ptr ← next.
  - Latency: first pattern appears at edge N+1.
- Step advance:
  - fwd: wraps seq_len-1 → 0.
  - rev: wraps 0 → seq_len-1.
  - ping-pong: 0..L-1..1,0,1… with endpoints shown once per turn.
  - L=1: ptr stays 0 in all modes.
- dir changes mid-play: take effect on the next advance from the current ptr. Switching into ping-pong sets flag=up.
- In PLAY, wr_ready=0 and writes are ignored. cmd_rec → RECORD (seq_len=0). cmd_stop → IDLE with pat_out=0 on the same edge.
- Arithmetic: pointers are ADDR_W bits; seq_len is ADDR_W+1 bits. Compare against seq_len-1 explicitly; never rely on power-of-two wrap.
- Reset mid-operation: immediate return to the reset values above. The recorded length is lost.

Optional Feature:
- Macro: SEQUENCER_LOOP_COUNT_EN.
- With the macro defined:
  - loop_count is sampled at PLAY entry.
  - One pass = L steps for fwd/rev; 2L-2 steps for ping-pong (1 if L=1).
  - After loop_count passes, the final pattern is shown for its step. On the next edge: state → IDLE, pat_out=0, done=1 for one cycle.
  - loop_count=0 plays forever.
- Without the macro: loop_count and done ports are absent; playback is infinite.

Decomposition:
- Package seq_pkg: state encodings (ST_IDLE, ST_RECORD, ST_PLAY), dir encodings (DIR_FWD, DIR_REV, DIR_PINGPONG).
- Sub-module seq_mem:
  - Register array DEPTH×WIDTH, synchronous write on div_clk, combinational read.
  - No reset on storage.
  - Top registers pat_out from its read data.

Test Plan (WIDTH=2, DEPTH=8):
- Record: rst; cmd_rec; write 1,2,3; cmd_play, dir=00 → seq_len=3; pat_out 1,2,3,1,2,… starting one edge after play; wr_ready=0 in PLAY.
- Full: cmd_rec; write 8 values 0..3,0..3 → wr_ready drops after 8th; 9th write ignored; seq_len=8.
- Reverse/ping-pong, L=4 data 0,1,2,3:
  - dir=01 → 3,2,1,0,3.
  - dir=10 → 0,1,2,3,2,1,0,1.
  - L=1, dir=10 → constant data.
- Commands: simultaneous cmd_stop+cmd_play in PLAY → IDLE, pat_out=0. cmd_play with seq_len=0 → stays IDLE.
- Reset: assert rst asynchronously between edges mid-PLAY → outputs to 0 immediately; state=IDLE; seq_len=0.
- SEQUENCER_LOOP_COUNT_EN: L=3, fwd, loop_count=2 → 6 patterns, then IDLE with done pulse of 1 cycle. loop_count=0 → no done after 100 steps.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the step pattern sequencer: FSM states and playback directions.
package seq_pkg;
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RECORD = 2'b01;
    localparam logic [1:0] ST_PLAY   = 2'b10;

    localparam logic [1:0] DIR_FWD      = 2'b00;
    localparam logic [1:0] DIR_REV      = 2'b01;
    localparam logic [1:0] DIR_PINGPONG = 2'b10;
endpackage

// File: rtl/seq_mem.sv
// Pattern storage: DEPTH x WIDTH register array, synchronous write, combinational read, no reset.
module seq_mem #(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              div_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge div_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/step_pattern_sequencer.sv
// Records up to DEPTH patterns and replays the recorded length forward, reverse or ping-pong.
// Define SEQUENCER_LOOP_COUNT_EN to add finite pass counting (loop_count in, done pulse out).
module step_pattern_sequencer
    import seq_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              div_clk,
    input  logic              rst,
    input  logic              cmd_rec,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic [1:0]        dir,
    input  logic              wr_valid,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    output logic [WIDTH-1:0]  pat_out,
    output logic [ADDR_W-1:0] step_idx,
    output logic [ADDR_W:0]   seq_len,
    output logic [1:0]        state
`ifdef SEQUENCER_LOOP_COUNT_EN
    ,
    input  logic [7:0]        loop_count,
    output logic              done
`endif
);
    localparam logic [ADDR_W:0]   LEN_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    logic [ADDR_W-1:0] ptr, nxt_ptr, entry_ptr;
    logic              up, nxt_up, pp_up;
    logic [1:0]        dir_q;
    logic [ADDR_W:0]   last, len_nxt, last_nxt;
    logic              accept, at_last, at_first;
    logic [WIDTH-1:0]  rdata;

    assign wr_ready = (state == ST_RECORD) && (seq_len < LEN_MAX);
    assign accept   = wr_valid && wr_ready;
    assign len_nxt  = accept ? seq_len + LEN_ONE : seq_len;
    assign last     = seq_len - LEN_ONE;
    assign last_nxt = len_nxt - LEN_ONE;
    assign at_last  = ({1'b0, ptr} == last);
    assign at_first = (ptr == '0);
    // A fresh switch into ping-pong always starts heading up.
    assign pp_up     = (dir_q != DIR_PINGPONG) || up;
    assign entry_ptr = (dir == DIR_REV) ? last_nxt[ADDR_W-1:0] : '0;

    always_comb begin
        nxt_ptr = ptr;
        nxt_up  = up;
        if (seq_len == LEN_ONE) begin
            nxt_ptr = '0;
            nxt_up  = 1'b1;
        end else begin
            case (dir)
                DIR_REV: nxt_ptr = at_first ? last[ADDR_W-1:0] : ptr - PTR_ONE;
                DIR_PINGPONG: begin
                    if (pp_up) begin
                        nxt_up  = !at_last;
                        nxt_ptr = at_last ? ptr - PTR_ONE : ptr + PTR_ONE;
                    end else begin
                        nxt_up  = at_first;
                        nxt_ptr = at_first ? ptr + PTR_ONE : ptr - PTR_ONE;
                    end
                end
                default: nxt_ptr = at_last ? '0 : ptr + PTR_ONE;
            endcase
        end
    end

`ifdef SEQUENCER_LOOP_COUNT_EN
    localparam logic [ADDR_W+9:0] REM_ONE = 1;
    logic [ADDR_W+1:0] pass_len;
    logic [ADDR_W+9:0] total, rem;
    logic              infinite, finished;

    // One pass: L steps fwd/rev, 2L-2 ping-pong, and a single step when L=1.
    assign pass_len = (len_nxt == LEN_ONE) ? (ADDR_W+2)'(1) :
                      (dir == DIR_PINGPONG) ? {len_nxt, 1'b0} - (ADDR_W+2)'(2) :
                      {1'b0, len_nxt};
    assign total    = {{(ADDR_W+2){1'b0}}, loop_count} * {8'd0, pass_len};
    assign finished = !infinite && (rem == '0);
`endif

    seq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .div_clk (div_clk),
        .we      (accept),
        .waddr   (seq_len[ADDR_W-1:0]),
        .wdata   (wr_data),
        .raddr   (ptr),
        .rdata   (rdata)
    );

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            seq_len  <= '0;
            pat_out  <= '0;
            step_idx <= '0;
            ptr      <= '0;
            up       <= 1'b1;
            dir_q    <= DIR_FWD;
`ifdef SEQUENCER_LOOP_COUNT_EN
            done     <= 1'b0;
            rem      <= '0;
            infinite <= 1'b0;
`endif
        end else begin
            dir_q <= dir;
`ifdef SEQUENCER_LOOP_COUNT_EN
            done  <= 1'b0;
            if ((state != ST_PLAY) && cmd_play && !cmd_stop && !cmd_rec) begin
                rem      <= total;
                infinite <= (loop_count == 8'd0);
            end
`endif
            case (state)
                ST_IDLE: begin
                    pat_out <= '0;
                    if (cmd_stop) begin
                    end else if (cmd_rec) begin
                        state   <= ST_RECORD;
                        seq_len <= '0;
                    end else if (cmd_play && seq_len != '0) begin
                        state <= ST_PLAY;
                        ptr   <= entry_ptr;
                        up    <= 1'b1;
                    end
                end
                ST_RECORD: begin
                    if (accept) begin
                        pat_out  <= wr_data;
                        step_idx <= seq_len[ADDR_W-1:0];
                    end
                    seq_len <= len_nxt;
                    if (cmd_stop) begin
                        state   <= ST_IDLE;
                        pat_out <= '0;
                    end else if (cmd_rec) begin
                        seq_len <= '0;
                    end else if (cmd_play) begin
                        if (len_nxt != '0) begin
                            state <= ST_PLAY;
                            ptr   <= entry_ptr;
                            up    <= 1'b1;
                        end else begin
                            state   <= ST_IDLE;
                            pat_out <= '0;
                        end
                    end
                end
                ST_PLAY: begin
                    if (cmd_stop) begin
                        state   <= ST_IDLE;
                        pat_out <= '0;
                    end else if (cmd_rec) begin
                        state   <= ST_RECORD;
                        seq_len <= '0;
`ifdef SEQUENCER_LOOP_COUNT_EN
                    end else if (finished) begin
                        state   <= ST_IDLE;
                        pat_out <= '0;
                        done    <= 1'b1;
`endif
                    end else begin
                        pat_out  <= rdata;
                        step_idx <= ptr;
                        ptr      <= nxt_ptr;
                        up       <= nxt_up;
`ifdef SEQUENCER_LOOP_COUNT_EN
                        if (!infinite) rem <= rem - REM_ONE;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_step_pattern_sequencer.sv
// Directed self-checking bench for step_pattern_sequencer (WIDTH=2, DEPTH=8).
module tb_step_pattern_sequencer;
    logic       div_clk = 1'b0;
    logic       rst, cmd_rec, cmd_play, cmd_stop, wr_valid, wr_ready;
    logic [1:0] dir, wr_data, pat_out, state;
    logic [2:0] step_idx;
    logic [3:0] seq_len;
`ifdef SEQUENCER_LOOP_COUNT_EN
    logic [7:0] loop_count;
    logic       done;
`endif
    int checks = 0;
    int passes = 0;

    step_pattern_sequencer #(.WIDTH(2), .DEPTH(8)) dut (
        .div_clk(div_clk), .rst(rst), .cmd_rec(cmd_rec), .cmd_play(cmd_play),
        .cmd_stop(cmd_stop), .dir(dir), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .pat_out(pat_out), .step_idx(step_idx),
        .seq_len(seq_len), .state(state)
`ifdef SEQUENCER_LOOP_COUNT_EN
        , .loop_count(loop_count), .done(done)
`endif
    );

    always #5 div_clk = ~div_clk;

    task automatic step();
        @(posedge div_clk);
        #1;
    endtask

    // Records n values; value i is vals[2i+1:2i].
    task automatic rec_seq(input logic [15:0] vals, input int n);
        cmd_rec = 1'b1; step(); cmd_rec = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1; wr_data = vals[2*i +: 2]; step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic play_start(input logic [1:0] d);
        dir = d; cmd_play = 1'b1; step(); cmd_play = 1'b0;
    endtask

    task automatic stop_now();
        cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'b00) $display("FAIL reset_state: got %0d want 0", state); else passes++;
        checks++; if (seq_len !== 4'd0) $display("FAIL reset_len: got %0d want 0", seq_len); else passes++;
        checks++; if (pat_out !== 2'd0 || step_idx !== 3'd0) $display("FAIL reset_out: pat %0d idx %0d want 0 0", pat_out, step_idx); else passes++;
        checks++; if (wr_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", wr_ready); else passes++;
    endtask

    task automatic test_record();
        logic [1:0] exp [5];
        logic [2:0] eidx [5];
        exp  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        eidx = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        cmd_rec = 1'b1; step(); cmd_rec = 1'b0;
        checks++; if (state !== 2'b01 || wr_ready !== 1'b1) $display("FAIL rec_enter: state %0d ready %0b want 1 1", state, wr_ready); else passes++;
        for (int i = 1; i <= 3; i++) begin
            wr_valid = 1'b1; wr_data = 2'(i); step();
            checks++;
            if (pat_out !== 2'(i) || step_idx !== 3'(i-1) || seq_len !== 4'(i))
                $display("FAIL rec_echo %0d: pat %0d idx %0d len %0d want %0d %0d %0d", i, pat_out, step_idx, seq_len, i, i-1, i);
            else passes++;
        end
        wr_valid = 1'b0;
        play_start(2'b00);
        checks++; if (state !== 2'b10 || pat_out !== 2'd3 || wr_ready !== 1'b0)
            $display("FAIL play_entry: state %0d pat %0d ready %0b want 2 3 0", state, pat_out, wr_ready); else passes++;
        wr_valid = 1'b1; wr_data = 2'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (pat_out !== exp[i] || step_idx !== eidx[i])
                $display("FAIL fwd_play %0d: pat %0d idx %0d want %0d %0d", i, pat_out, step_idx, exp[i], eidx[i]);
            else passes++;
        end
        wr_valid = 1'b0;
        checks++; if (seq_len !== 4'd3) $display("FAIL play_no_write: len %0d want 3", seq_len); else passes++;
    endtask

    task automatic test_full();
        cmd_rec = 1'b1; step(); cmd_rec = 1'b0;
        checks++; if (seq_len !== 4'd0 || state !== 2'b01) $display("FAIL full_restart: len %0d state %0d want 0 1", seq_len, state); else passes++;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_data = 2'(i % 4);
            if (i == 7) begin
                checks++; if (wr_ready !== 1'b1) $display("FAIL full_ready_before8: got %0b want 1", wr_ready); else passes++;
            end
            step();
        end
        checks++; if (wr_ready !== 1'b0 || seq_len !== 4'd8) $display("FAIL full_after8: ready %0b len %0d want 0 8", wr_ready, seq_len); else passes++;
        wr_data = 2'd1; step(); wr_valid = 1'b0;
        checks++; if (seq_len !== 4'd8 || pat_out !== 2'd3 || step_idx !== 3'd7)
            $display("FAIL full_9th_ignored: len %0d pat %0d idx %0d want 8 3 7", seq_len, pat_out, step_idx); else passes++;
        play_start(2'b11);
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (pat_out !== 2'((i % 8) % 4) || step_idx !== 3'(i % 8))
                $display("FAIL full_wrap %0d: pat %0d idx %0d want %0d %0d", i, pat_out, step_idx, (i%8)%4, i%8);
            else passes++;
        end
        stop_now();
    endtask

    task automatic test_rev_pingpong();
        logic [1:0] erev [5];
        logic [1:0] epp [8];
        erev = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        epp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        rec_seq({8'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 4);
        play_start(2'b01);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (pat_out !== erev[i]) $display("FAIL rev %0d: pat %0d want %0d", i, pat_out, erev[i]); else passes++;
        end
        stop_now();
        play_start(2'b10);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (pat_out !== epp[i] || step_idx !== 3'(epp[i]))
                $display("FAIL pingpong %0d: pat %0d idx %0d want %0d", i, pat_out, step_idx, epp[i]); else passes++;
        end
        stop_now();
        rec_seq({14'd0, 2'd2}, 1);
        play_start(2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pat_out !== 2'd2 || step_idx !== 3'd0)
                $display("FAIL len1_pp %0d: pat %0d idx %0d want 2 0", i, pat_out, step_idx); else passes++;
        end
    endtask

    task automatic test_commands();
        cmd_stop = 1'b1; cmd_play = 1'b1; step(); cmd_stop = 1'b0; cmd_play = 1'b0;
        checks++; if (state !== 2'b00 || pat_out !== 2'd0) $display("FAIL stop_over_play: state %0d pat %0d want 0 0", state, pat_out); else passes++;
        cmd_rec = 1'b1; step(); cmd_rec = 1'b0;
        stop_now();
        checks++; if (seq_len !== 4'd0) $display("FAIL empty_len: got %0d want 0", seq_len); else passes++;
        play_start(2'b00);
        checks++; if (state !== 2'b00) $display("FAIL play_empty: state %0d want 0", state); else passes++;
        rec_seq({12'd0, 2'd2, 2'd1}, 2);
        play_start(2'b00);
        step();
        cmd_rec = 1'b1; cmd_play = 1'b1; step(); cmd_rec = 1'b0; cmd_play = 1'b0;
        checks++; if (state !== 2'b01 || seq_len !== 4'd0) $display("FAIL rec_over_play: state %0d len %0d want 1 0", state, seq_len); else passes++;
    endtask

    task automatic test_async_reset();
        rec_seq({10'd0, 2'd3, 2'd2, 2'd1}, 3);
        play_start(2'b00);
        step(); step();
        checks++; if (pat_out !== 2'd2) $display("FAIL pre_reset_pat: got %0d want 2", pat_out); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (pat_out !== 2'd0 || state !== 2'b00 || seq_len !== 4'd0 || step_idx !== 3'd0)
            $display("FAIL async_reset: pat %0d state %0d len %0d idx %0d want 0 0 0 0", pat_out, state, seq_len, step_idx); else passes++;
        #1 rst = 1'b0;
        play_start(2'b00);
        checks++; if (state !== 2'b00) $display("FAIL play_after_reset: state %0d want 0", state); else passes++;
    endtask

`ifdef SEQUENCER_LOOP_COUNT_EN
    task automatic test_loop_count();
        logic saw_done;
        rec_seq({10'd0, 2'd3, 2'd2, 2'd1}, 3);
        loop_count = 8'd2;
        play_start(2'b00);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (pat_out !== 2'((i % 3) + 1) || state !== 2'b10 || done !== 1'b0)
                $display("FAIL loop_pat %0d: pat %0d state %0d done %0b want %0d 2 0", i, pat_out, state, done, (i%3)+1); else passes++;
        end
        step();
        checks++; if (state !== 2'b00 || pat_out !== 2'd0 || done !== 1'b1)
            $display("FAIL loop_end: state %0d pat %0d done %0b want 0 0 1", state, pat_out, done); else passes++;
        step();
        checks++; if (done !== 1'b0) $display("FAIL done_pulse: got %0b want 0", done); else passes++;
        loop_count = 8'd0;
        play_start(2'b10);
        saw_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            saw_done |= done;
        end
        checks++; if (saw_done !== 1'b0 || state !== 2'b10) $display("FAIL loop_infinite: done %0b state %0d want 0 2", saw_done, state); else passes++;
        stop_now();
    endtask
`endif

    initial begin
        rst = 1'b1; cmd_rec = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
        dir = 2'b00; wr_valid = 1'b0; wr_data = 2'd0;
`ifdef SEQUENCER_LOOP_COUNT_EN
        loop_count = 8'd0;
`endif
        #12;
        test_reset();
        rst = 1'b0;
        test_record();
        test_full();
        test_rev_pingpong();
        test_commands();
        test_async_reset();
`ifdef SEQUENCER_LOOP_COUNT_EN
        test_loop_count();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
